// File: rtl/uart_rx.sv
// 8N1-style serial receiver: start bit, data_width bits LSB first, stop bit.
// Samples mid-bit from a falling-edge start detect; one-cycle valid/frame_err strobes.
module uart_rx #(
   parameter int data_width   = 8,
   parameter int clks_per_bit = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  rx_en,
   input  logic                  rx,
   output logic [data_width-1:0] data,
   output logic                  valid,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   localparam int IW = (data_width > 1) ? $clog2(data_width) : 1;
   // Counter counts down to zero, so a period of N cycles is loaded as N-1.
   localparam logic [CW-1:0] HALF_LOAD = CW'(clks_per_bit / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(clks_per_bit - 1);
   localparam logic [IW-1:0] LAST_BIT  = IW'(data_width - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state_q, state_d;
   logic                  rx_meta_q, rx_s_q, rx_dly_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [data_width-1:0] shift_q, shift_d;
   logic [data_width-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  ferr_q, ferr_d;
   logic                  expire;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_dly_q  <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_dly_q  <= rx_s_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      expire  = (cnt_q == '0);

      if (state_q != IDLE && !expire) cnt_d = cnt_q - 1'b1;

      unique case (state_q)
         IDLE: begin
            if (rx_en && rx_dly_q && !rx_s_q) begin
               cnt_d   = HALF_LOAD;
               state_d = START;
            end
         end
         START: begin
            if (expire) begin
               if (rx_s_q) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = FULL_LOAD;
                  idx_d   = '0;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (expire) begin
               shift_d                 = shift_q >> 1;
               shift_d[data_width-1]   = rx_s_q;
               cnt_d                   = FULL_LOAD;
               if (idx_q == LAST_BIT) state_d = STOP;
               else                   idx_d   = idx_q + 1'b1;
            end
         end
         STOP: begin
            if (expire) begin
               state_d = IDLE;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: sample-time reference model compared every cycle,
// plus literal checks on latency, pulse spacing and held data.
module tb_uart_rx;

   localparam int W        = 8;
   localparam int CPB      = 16;
   localparam int HALF     = CPB / 2;
   localparam int STOP_OFS = HALF + (W + 1) * CPB;

   logic         clk = 1'b0;
   logic         arst_n;
   logic         rx_en;
   logic         rx;
   logic [W-1:0] data;
   logic         valid;
   logic         busy;
   logic         frame_err;

   uart_rx #(.data_width(W), .clks_per_bit(CPB)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .rx_en     (rx_en),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: a frame starting at edge m_start samples the synchronized
   // line at fixed offsets HALF, HALF+(j+1)*CPB and STOP_OFS.
   int unsigned  k = 0;
   int unsigned  m_start = 0;
   int unsigned  ofs = 0;
   bit           m_meta = 1'b1, m_s = 1'b1, m_prev = 1'b1, m_active = 1'b0;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] exp_data = '0;
   bit           exp_valid = 1'b0, exp_ferr = 1'b0, exp_busy = 1'b0;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         m_meta = 1'b1; m_s = 1'b1; m_prev = 1'b1; m_active = 1'b0;
         exp_data = '0; exp_valid = 1'b0; exp_ferr = 1'b0; exp_busy = 1'b0;
      end else begin
         k++;
         exp_valid = 1'b0;
         exp_ferr  = 1'b0;
         if (m_active) begin
            ofs = k - m_start;
            if (ofs == HALF && m_s) begin
               m_active = 1'b0;
            end else if (ofs == STOP_OFS) begin
               m_active = 1'b0;
               if (m_s) begin
                  exp_data  = m_word;
                  exp_valid = 1'b1;
               end else begin
                  exp_ferr = 1'b1;
               end
            end else if (ofs > HALF && ((ofs - HALF) % CPB) == 0) begin
               m_word[(ofs - HALF) / CPB - 1] = m_s;
            end
         end else if (rx_en && m_prev && !m_s) begin
            m_active = 1'b1;
            m_start  = k;
         end
         exp_busy = m_active;
         m_prev = m_s;
         m_s    = m_meta;
         m_meta = rx;
      end
   end

   // Per-cycle compare plus observation counters for the literal checks.
   int           cyc = 0, busy_rise = 0, busy_len = 0, valid_lat = 0;
   int           valid_cnt = 0, ferr_cnt = 0, last_valid_at = 0, prev_valid_at = 0;
   logic [W-1:0] last_valid_data = '0, prev_valid_data = '0;
   bit           prev_busy = 1'b0;

   always @(negedge clk) begin
      cyc++;
      vectors++;
      if (valid !== exp_valid || frame_err !== exp_ferr || busy !== exp_busy || data !== exp_data) begin
         miscompares++;
         $display("FAIL cycle %0d outputs: got valid=%b ferr=%b busy=%b data=%h, expected valid=%b ferr=%b busy=%b data=%h",
                  cyc, valid, frame_err, busy, data, exp_valid, exp_ferr, exp_busy, exp_data);
      end
      if (busy && !prev_busy) busy_rise = cyc;
      if (!busy && prev_busy) busy_len = cyc - busy_rise;
      if (valid) begin
         valid_cnt++;
         prev_valid_at   = last_valid_at;
         last_valid_at   = cyc;
         prev_valid_data = last_valid_data;
         last_valid_data = data;
         valid_lat       = cyc - busy_rise;
      end
      if (frame_err) ferr_cnt++;
      prev_busy = busy;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] d, input bit stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < W; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   int v0, f0;
   logic [W-1:0] w;

   initial begin
      arst_n = 1'b0;
      rx_en  = 1'b1;
      rx     = 1'b1;
      repeat (5) @(negedge clk);
      check("reset data", data, 0);
      check("reset busy", busy, 0);
      check("reset valid", valid, 0);
      check("reset frame_err", frame_err, 0);
      arst_n = 1'b1;
      idle(10);

      // single frame
      send(8'hA5, 1'b1);
      idle(20);
      check("A5 data", last_valid_data, 8'hA5);
      check("A5 valid latency", valid_lat, 152);
      check("A5 busy length", busy_len, 152);
      check("A5 valid count", valid_cnt, 1);
      check("A5 frame_err count", ferr_cnt, 0);

      // back-to-back
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      idle(20);
      check("b2b valid count", valid_cnt, 3);
      check("b2b spacing", last_valid_at - prev_valid_at, 160);
      check("b2b first word", prev_valid_data, 8'h00);
      check("b2b second word", last_valid_data, 8'hFF);

      // glitch
      rx = 1'b0;
      repeat (4) @(negedge clk);
      idle(30);
      check("glitch valid count", valid_cnt, 3);
      check("glitch frame_err count", ferr_cnt, 0);
      check("glitch busy length", busy_len, 8);
      send(8'h3C, 1'b1);
      idle(20);
      check("post-glitch data", data, 8'h3C);

      // framing error, then line held low
      send(8'h11, 1'b1);
      idle(20);
      v0 = valid_cnt;
      send(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (400) @(negedge clk);
      idle(40);
      check("ferr count", ferr_cnt, 1);
      check("ferr valid count", valid_cnt, v0);
      check("ferr data held", data, 8'h11);

      // reset mid-frame during data bit 3
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b0;
      repeat (5) @(negedge clk);
      check("busy before reset", busy, 1);
      #2 arst_n = 1'b0;
      #1;
      check("async reset data", data, 0);
      check("async reset busy", busy, 0);
      check("async reset valid", valid, 0);
      check("async reset frame_err", frame_err, 0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      arst_n = 1'b1;
      idle(10);
      v0 = valid_cnt;
      send(8'h5A, 1'b1);
      idle(20);
      check("post-reset data", data, 8'h5A);
      check("post-reset valid count", valid_cnt, v0 + 1);

      // rx_en low blocks a frame
      v0 = valid_cnt;
      rx_en = 1'b0;
      send(8'hC3, 1'b1);
      idle(20);
      rx_en = 1'b1;
      check("rx_en blocked", valid_cnt, v0);

      // 256 random words back-to-back
      v0 = valid_cnt;
      f0 = ferr_cnt;
      for (int n = 0; n < 256; n++) begin
         w = W'($urandom);
         send(w, 1'b1);
      end
      idle(40);
      check("loopback valid count", valid_cnt, v0 + 256);
      check("loopback frame_err count", ferr_cnt, f0);
      check("loopback last word", data, w);

      // random gaps, stop-bit errors and rx_en changes
      for (int n = 0; n < 32; n++) begin
         rx_en = ($urandom_range(0, 3) != 0);
         send(W'($urandom), ($urandom_range(0, 7) != 0));
         idle($urandom_range(0, 40));
      end
      rx_en = 1'b1;
      idle(400);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
